alu4_result_stage: RTL and testbench
====================================

# alu4_result_stage

Registered result stage that sits directly downstream of the 4-bit ALU function units (OR, AND, XOR, ADD). Each accepted operation selects one unit's 4-bit output, derives zero/carry flags, and stores it in a 2-entry FIFO. Entries drain toward the register-file write-back through a valid/ready handshake. A wrapping 8-bit operation counter supports bench and debug visibility.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; fixed, not overridable in this revision.
- CNT_W, 8, width of operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operation present.
- in_ready  out  1  stage can accept this cycle.
- sel  in  2  unit select: 00 OR, 01 AND, 10 XOR, 11 ADD.
- or_r  in  4  OR unit result (o3..o0 of the OR unit).
- and_r  in  4  AND unit result.
- xor_r  in  4  XOR unit result.
- sum_r  in  4  adder sum.
- cout  in  1  adder carry-out.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts head.
- r  out  4  head result.
- z  out  1  head zero flag.
- c  out  1  head carry flag.
- ops_cnt  out  CNT_W  count of accepted operations, wrapping.
- p  out  1  head parity (only with ALU4_PARITY_EN).

## Operation
- Push: in_valid && in_ready. Store {res, z, c} at the tail, where:
  - res = unit output selected by sel;
  - z = (res == 4'b0000);
  - c = cout when sel == 11, else 0.
- Pop: out_valid && out_ready removes the head.
- in_ready = (count < 2) && !rst. A full FIFO does not accept input, even when a pop occurs in the same cycle (no pass-through when full).
- out_valid = (count != 0).
- Head outputs:
  - r/z/c/p show the head entry.
  - When the FIFO is empty, r/z/c/p drive 0.
- Count update:
  - push and pop together with 0 < count < 2: count unchanged, order preserved.
  - push only: count + 1.
  - pop only: count − 1.
- Occupancy states:
  - EMPTY (count 0): push → ONE.
  - ONE (count 1): push only → FULL; pop only → EMPTY; push + pop → ONE.
  - FULL (count 2): pop → ONE; push is blocked.
- ops_cnt increments by 1 on every push and wraps 255 → 0. Pops do not affect it.
- Inputs are sampled only on push. Changes to sel or the data inputs while in_ready = 0 are ignored.

## Timing
- Latency: a push at edge N makes out_valid = 1, with the entry's r/z/c, after edge N (one cycle). There is no combinational input-to-output path.
- Throughput: one push and one pop per cycle in the ONE state.
- in_ready depends only on registered count and rst. It is never combinational from out_ready.
- Reset values: count 0, out_valid 0, r 4'h0, z 0, c 0, p 0, ops_cnt 0, in_ready 0 while rst = 1. in_ready is 1 the cycle after rst deasserts.
- Reset mid-operation: rst has priority over push and pop in the same cycle. All entries are discarded and ops_cnt is cleared.
- Upstream unit gate delays (2 units OR, 1 unit inverter/pass) must settle within one clk period. Inputs are sampled only at the edge.

## Configuration
- ALU4_PARITY_EN defined:
  - FIFO entry width becomes 7 bits, adding p = ^res computed at push.
  - Port p exists and shows head parity, or 0 when empty.
- ALU4_PARITY_EN undefined:
  - Port p is absent and entries are 6 bits.
  - All other behaviour is identical.

## Test plan
- Reset, then sel=00, or_r=4'b1010, single push → next cycle out_valid=1, r=1010, z=0, c=0; with out_ready=1, out_valid=0 the following cycle.
- sel=11, sum_r=4'b0000, cout=1 → r=0000, z=1, c=1. Then sel=01, and_r=0000, cout=1 → z=1, c=0 (carry masked for non-ADD).
- out_ready=0, three consecutive pushes (0x1, 0x2, 0x3) → in_ready drops after the 2nd push, 3rd is not accepted, ops_cnt=2. Drain yields 0x1 then 0x2.
- Count=1, push 0x5 and pop at the same edge, repeated 4 cycles with data 0x5..0x8 → count stays 1, outputs appear in order, in_ready stays 1.
- 256 pushes with out_ready=1 → ops_cnt returns to 0x00. Assert rst while FULL → next cycle out_valid=0, r=0, ops_cnt=0.
- With ALU4_PARITY_EN: sel=10, xor_r=4'b0111 → p=1; xor_r=4'b0110 → p=0.

Source files
------------

// File: rtl/alu4_result_stage_if.sv
// -----------------------------------------------------------------------------
// alu4_result_stage_if
//
// Bundles the handshake and data signals of the ALU result stage.
//   Upstream side : in_valid, in_ready, sel, or_r, and_r, xor_r, sum_r, cout
//   Downstream    : out_valid, out_ready, r, z, c, p (p only with ALU4_PARITY_EN)
//   Debug         : ops_cnt (CNT_W bits, wrapping count of accepted operations)
//
// Modports:
//   master - the environment: drives the upstream operation and out_ready.
//   slave  - the result stage itself.
//
// Optional feature macro: ALU4_PARITY_EN adds the head parity signal p.
// -----------------------------------------------------------------------------
interface alu4_result_stage_if #(
  parameter int CNT_W = 8
);

  // Upstream operation
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic [3:0]       or_r;
  logic [3:0]       and_r;
  logic [3:0]       xor_r;
  logic [3:0]       sum_r;
  logic             cout;

  // Downstream head entry
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       r;
  logic             z;
  logic             c;
`ifdef ALU4_PARITY_EN
  logic             p;
`endif

  // Debug visibility
  logic [CNT_W-1:0] ops_cnt;

  modport master (
    output in_valid, sel, or_r, and_r, xor_r, sum_r, cout, out_ready,
    input  in_ready, out_valid, r, z, c,
`ifdef ALU4_PARITY_EN
    input  p,
`endif
    input  ops_cnt
  );

  modport slave (
    input  in_valid, sel, or_r, and_r, xor_r, sum_r, cout, out_ready,
    output in_ready, out_valid, r, z, c,
`ifdef ALU4_PARITY_EN
    output p,
`endif
    output ops_cnt
  );

endinterface

// File: rtl/alu4_result_stage.sv
// -----------------------------------------------------------------------------
// alu4_result_stage
//
// Registered result stage downstream of the 4-bit OR/AND/XOR/ADD units. Each
// accepted operation picks one unit's result, derives zero and carry flags and
// is queued in a 2-entry FIFO that drains through a valid/ready handshake.
//
// Ports:
//   clk  - single clock, rising edge.
//   rst  - synchronous, active-high reset (priority over push and pop).
//   bus  - alu4_result_stage_if.slave:
//            in_valid/in_ready, sel, or_r, and_r, xor_r, sum_r, cout (upstream)
//            out_valid/out_ready, r, z, c, p (downstream head entry)
//            ops_cnt (wrapping count of accepted operations)
//
// Optional feature macro: ALU4_PARITY_EN
//   defined   - entries carry p = ^res, exposed on bus.p (0 when empty).
//   undefined - no parity bit, no p port.
//
// Structure: the FIFO is a two-slot shift arrangement. The head always lives in
// head_q, so r/z/c/p are driven straight from flops with no read mux; the
// second entry waits in tail_q. The occupancy FSM state equals the entry count.
// -----------------------------------------------------------------------------
module alu4_result_stage #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu4_result_stage_if.slave  bus
);

  // Fixed FIFO depth for this revision.
  localparam int unsigned DEPTH = 2;

  // Occupancy states; the encoding is the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // One queued result.
  typedef struct packed {
    logic [3:0] res;
    logic       z;
    logic       c;
`ifdef ALU4_PARITY_EN
    logic       p;
`endif
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  occ_state_e        state_q, state_d;
  entry_t            head_q,  head_d;
  entry_t            tail_q,  tail_d;
  logic [CNT_W-1:0]  ops_cnt_q, ops_cnt_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // in_ready depends only on the registered occupancy and rst, so a full FIFO
  // refuses input even when the head is being popped in the same cycle.
  assign in_ready  = ({30'd0, state_q} < DEPTH) && !rst;
  assign out_valid = (state_q != EMPTY);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  // ---------------------------------------------------------------------------
  // Entry formation from the selected unit
  // ---------------------------------------------------------------------------
  entry_t     new_entry;
  logic [3:0] sel_res;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    sel_res = 4'h0;
    unique case (bus.sel)
      2'b00:   sel_res = bus.or_r;
      2'b01:   sel_res = bus.and_r;
      2'b10:   sel_res = bus.xor_r;
      2'b11:   sel_res = bus.sum_r;
      default: sel_res = 4'h0;
    endcase

    new_entry     = '0;
    new_entry.res = sel_res;
    new_entry.z   = (sel_res == 4'h0);
    // Carry only has meaning for the adder; logic units never report one.
    new_entry.c   = (bus.sel == 2'b11) ? bus.cout : 1'b0;
`ifdef ALU4_PARITY_EN
    new_entry.p   = ^sel_res;
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    ops_cnt_d = ops_cnt_q + CNT_W'(push);

    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end

      ONE: begin
        if (push && pop) begin
          // Old head leaves as the new entry takes its place.
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = FULL;
        end else if (pop) begin
          // Clearing the head keeps r/z/c/p at 0 while empty.
          head_d  = '0;
          state_d = EMPTY;
        end
      end

      FULL: begin
        // push cannot occur here: in_ready is low.
        if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end
      end

      default: begin
        state_d = EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  // NOTE: the two storage slots are reset as well, since head_q drives the
  // outputs directly and must read as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      ops_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      ops_cnt_q <= ops_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.r         = head_q.res;
  assign bus.z         = head_q.z;
  assign bus.c         = head_q.c;
`ifdef ALU4_PARITY_EN
  assign bus.p         = head_q.p;
`endif
  assign bus.ops_cnt   = ops_cnt_q;

endmodule

// File: tb/tb_alu4_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu4_result_stage
//
// Self-checking bench for alu4_result_stage. A queue-based reference model
// follows the behaviour of the stage; table vectors, directed sequences and a
// randomized run are all compared against it, and the table and directed
// sequences also compare against hand-written constants.
// -----------------------------------------------------------------------------
module tb_alu4_result_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu4_result_stage_if #(.CNT_W(8)) bus ();

  alu4_result_stage #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of stored results plus an accepted-op counter.
  typedef struct {
    logic [3:0] r;
    logic       z;
    logic       c;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic v, input logic [1:0] s, input logic [3:0] o,
                       input logic [3:0] a, input logic [3:0] x, input logic [3:0] su,
                       input logic co, input logic ordy);
    bus.in_valid  = v;
    bus.sel       = s;
    bus.or_r      = o;
    bus.and_r     = a;
    bus.xor_r     = x;
    bus.sum_r     = su;
    bus.cout      = co;
    bus.out_ready = ordy;
  endtask

  // One clock cycle: check in_ready before the edge, advance the model, then
  // compare every head output after the edge.
  task automatic tick();
    logic   acc;
    logic   take;
    m_ent_t e;
    m_ent_t h;
    #1;
    acc = (mq.size() < 2) && !rst;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, acc});
    acc  = acc && bus.in_valid;
    take = (mq.size() > 0) && bus.out_ready;
    case (bus.sel)
      2'b00:   e.r = bus.or_r;
      2'b01:   e.r = bus.and_r;
      2'b10:   e.r = bus.xor_r;
      default: e.r = bus.sum_r;
    endcase
    e.z = (e.r == 4'd0);
    e.c = (bus.sel == 2'b11) ? bus.cout : 1'b0;

    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (take) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        m_cnt = (m_cnt + 1) % 256;
      end
    end

    h = '{r: 4'd0, z: 1'b0, c: 1'b0};
    if (mq.size() > 0) h = mq[0];
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
    check("r",         {28'd0, bus.r},         {28'd0, h.r});
    check("z",         {31'd0, bus.z},         {31'd0, h.z});
    check("c",         {31'd0, bus.c},         {31'd0, h.c});
    check("ops_cnt",   {24'd0, bus.ops_cnt},   m_cnt);
`ifdef ALU4_PARITY_EN
    check("p",         {31'd0, bus.p},         {31'd0, ^h.r});
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  // Table vectors: single push into an empty FIFO, then drain.
  typedef struct {
    logic [1:0] sel;
    logic [3:0] or_r, and_r, xor_r, sum_r;
    logic       cout;
    logic [3:0] exp_r;
    logic       exp_z, exp_c, exp_p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 4'b1010, 4'h5, 4'h3, 4'hC, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 4'hA,    4'h5, 4'h3, 4'h0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 4'hA,    4'h0, 4'h3, 4'hC, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 4'hA,    4'h5, 4'h7, 4'hC, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 4'hA,    4'h5, 4'h6, 4'hC, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 4'hA,    4'h5, 4'h3, 4'hF, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b00, 4'h0,    4'hF, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 4'h0,    4'h0, 4'h0, 4'h9, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0};

    // Reset state
    do_reset();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_r",         {28'd0, bus.r},         32'd0);
    check("rst_ops_cnt",   {24'd0, bus.ops_cnt},   32'd0);
    #1;
    check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

    // Table-driven single pushes
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, vecs[i].sel, vecs[i].or_r, vecs[i].and_r, vecs[i].xor_r,
            vecs[i].sum_r, vecs[i].cout, 1'b0);
      tick();
      check("vec_valid", {31'd0, bus.out_valid}, 32'd1);
      check("vec_r",     {28'd0, bus.r},         {28'd0, vecs[i].exp_r});
      check("vec_z",     {31'd0, bus.z},         {31'd0, vecs[i].exp_z});
      check("vec_c",     {31'd0, bus.c},         {31'd0, vecs[i].exp_c});
`ifdef ALU4_PARITY_EN
      check("vec_p",     {31'd0, bus.p},         {31'd0, vecs[i].exp_p});
`endif
      apply(1'b0, 2'b00, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
      tick();
      check("vec_drained", {31'd0, bus.out_valid}, 32'd0);
    end

    // Back-pressure: three pushes with out_ready low, only two accepted
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      apply(1'b1, 2'b00, 4'(i), 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
    end
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full_ops_cnt",  {24'd0, bus.ops_cnt},  32'd2);
    apply(1'b1, 2'b00, 4'h9, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    check("drain_first", {28'd0, bus.r}, 32'h2);
    apply(1'b0, 2'b00, 4'h9, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    check("drain_empty", {31'd0, bus.out_valid}, 32'd0);

    // Streaming in ONE: push and pop together for four cycles
    do_reset();
    apply(1'b1, 2'b00, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    for (int i = 5; i <= 8; i++) begin
      apply(1'b1, 2'b00, 4'(i), 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      tick();
      check("stream_r",        {28'd0, bus.r},         i);
      check("stream_in_ready", {31'd0, bus.in_ready},  32'd1);
      check("stream_valid",    {31'd0, bus.out_valid}, 32'd1);
    end

    // ops_cnt wrap after 256 pushes, then reset while full
    do_reset();
    for (int i = 0; i < 256; i++) begin
      apply(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 4'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    check("ops_cnt_wrap", {24'd0, bus.ops_cnt}, 32'd0);
    apply(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 2'b01, 4'h0, 4'hD, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
    end
    check("prefull_ops_cnt", {24'd0, bus.ops_cnt}, 32'd2);
    rst = 1'b1;
    apply(1'b1, 2'b01, 4'h0, 4'hD, 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    check("midrst_valid",   {31'd0, bus.out_valid}, 32'd0);
    check("midrst_r",       {28'd0, bus.r},         32'd0);
    check("midrst_ops_cnt", {24'd0, bus.ops_cnt},   32'd0);
    rst = 1'b0;

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      apply(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
